// File: rtl/mem_arbiter.sv
// Shares one memory port between the instruction fetch unit and the load/store unit.
// One transaction in flight at a time; the LSU has priority, bounded so the IFU is not starved.
module mem_arbiter #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_LSU_BURST = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    ifu_req_valid_i,
   output logic                    ifu_req_ready_o,
   input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
   output logic                    ifu_rsp_valid_o,
   output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
   input  logic                    lsu_req_valid_i,
   output logic                    lsu_req_ready_o,
   input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
   input  logic                    lsu_wen_i,
   input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] lsu_wmask_i,
   output logic                    lsu_rsp_valid_o,
   output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
   output logic                    mem_req_valid_o,
   input  logic                    mem_req_ready_i,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic                    mem_wen_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
   input  logic                    mem_rsp_valid_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   output logic                    busy_o
);

   localparam int STREAK_WIDTH = $clog2(MAX_LSU_BURST + 1);
   localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_LSU_BURST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    owner;
   logic [STREAK_WIDTH-1:0] lsu_streak;
   logic                    grant_ifu;
   logic                    grant_lsu;
   logic                    rsp_fire;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (ifu_req_ready_o || lsu_req_ready_o) state_next = REQ;
         REQ:     if (mem_req_ready_i) state_next = WAIT;
         WAIT:    if (mem_rsp_valid_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Every handshake and status output is gated by reset so none of them glitch high during it.
   always_comb begin
      grant_lsu       = lsu_req_valid_i && !(ifu_req_valid_i && (lsu_streak == STREAK_MAX));
      grant_ifu       = ifu_req_valid_i && !grant_lsu;
      ifu_req_ready_o = rst_n_i && (state == IDLE) && grant_ifu;
      lsu_req_ready_o = rst_n_i && (state == IDLE) && grant_lsu;
      mem_req_valid_o = rst_n_i && (state == REQ);
      rsp_fire        = rst_n_i && (state == WAIT) && mem_rsp_valid_i;
      ifu_rsp_valid_o = rsp_fire && !owner;
      lsu_rsp_valid_o = rsp_fire && owner;
      busy_o          = rst_n_i && (state != IDLE);
      ifu_rdata_o     = mem_rdata_i;
      lsu_rdata_o     = mem_rdata_i;
   end

   // The streak only grows while the IFU is actually waiting; an uncontested LSU grant resets it.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         owner       <= 1'b0;
         lsu_streak  <= '0;
         mem_addr_o  <= '0;
         mem_wen_o   <= 1'b0;
         mem_wdata_o <= '0;
         mem_wmask_o <= '0;
      end else if (ifu_req_ready_o) begin
         owner       <= 1'b0;
         lsu_streak  <= '0;
         mem_addr_o  <= ifu_addr_i;
         mem_wen_o   <= 1'b0;
         mem_wdata_o <= '0;
         mem_wmask_o <= '0;
      end else if (lsu_req_ready_o) begin
         owner       <= 1'b1;
         mem_addr_o  <= lsu_addr_i;
         mem_wen_o   <= lsu_wen_i;
         mem_wdata_o <= lsu_wdata_i;
         mem_wmask_o <= lsu_wmask_i;
         if (!ifu_req_valid_i) begin
            lsu_streak <= '0;
         end else if (lsu_streak != STREAK_MAX) begin
            lsu_streak <= lsu_streak + STREAK_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a small memory model answers requests and
// every response strobe is compared against expectations queued when stimulus is driven.
module tb_mem_arbiter;

   typedef struct packed {
      logic        owner;
      logic [31:0] data;
   } rsp_t;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        ifu_req_valid_i;
   logic        ifu_req_ready_o;
   logic [31:0] ifu_addr_i;
   logic        ifu_rsp_valid_o;
   logic [31:0] ifu_rdata_o;
   logic        lsu_req_valid_i;
   logic        lsu_req_ready_o;
   logic [31:0] lsu_addr_i;
   logic        lsu_wen_i;
   logic [31:0] lsu_wdata_i;
   logic [3:0]  lsu_wmask_i;
   logic        lsu_rsp_valid_o;
   logic [31:0] lsu_rdata_o;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic [31:0] mem_addr_o;
   logic        mem_wen_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_wmask_o;
   logic        mem_rsp_valid_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o;

   logic        auto_mem;
   logic        auto_ready;
   logic        auto_rsp;
   logic [31:0] auto_rdata;
   logic [31:0] auto_addr;
   logic        man_ready;
   logic        man_rsp;
   logic [31:0] man_rdata;

   int   checks   = 0;
   int   failures = 0;
   rsp_t exp_q[$];
   rsp_t obs_q[$];
   bit   grant_q[$];

   assign mem_req_ready_i = auto_mem ? auto_ready : man_ready;
   assign mem_rsp_valid_i = auto_mem ? auto_rsp   : man_rsp;
   assign mem_rdata_i     = auto_mem ? auto_rdata : man_rdata;

   always #5 clk_i = ~clk_i;

   mem_arbiter #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .MAX_LSU_BURST(4)
   ) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .ifu_req_valid_i(ifu_req_valid_i),
      .ifu_req_ready_o(ifu_req_ready_o),
      .ifu_addr_i     (ifu_addr_i),
      .ifu_rsp_valid_o(ifu_rsp_valid_o),
      .ifu_rdata_o    (ifu_rdata_o),
      .lsu_req_valid_i(lsu_req_valid_i),
      .lsu_req_ready_o(lsu_req_ready_o),
      .lsu_addr_i     (lsu_addr_i),
      .lsu_wen_i      (lsu_wen_i),
      .lsu_wdata_i    (lsu_wdata_i),
      .lsu_wmask_i    (lsu_wmask_i),
      .lsu_rsp_valid_o(lsu_rsp_valid_o),
      .lsu_rdata_o    (lsu_rdata_o),
      .mem_req_valid_o(mem_req_valid_o),
      .mem_req_ready_i(mem_req_ready_i),
      .mem_addr_o     (mem_addr_o),
      .mem_wen_o      (mem_wen_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_wmask_o    (mem_wmask_o),
      .mem_rsp_valid_i(mem_rsp_valid_i),
      .mem_rdata_i    (mem_rdata_i),
      .busy_o         (busy_o)
   );

   function automatic logic [31:0] model_rdata(input logic [31:0] addr);
      return addr ^ 32'h8010_0073;
   endfunction

   // Memory model: accepts at once and answers one cycle later with data derived from the address.
   initial begin
      auto_ready = 1'b0;
      auto_rsp   = 1'b0;
      auto_rdata = '0;
      auto_addr  = '0;
      forever begin
         @(posedge clk_i); #1;
         if (auto_mem && mem_req_valid_o) begin
            auto_ready = 1'b1;
            auto_addr  = mem_addr_o;
            @(posedge clk_i); #1;
            auto_ready = 1'b0;
            auto_rsp   = 1'b1;
            auto_rdata = model_rdata(auto_addr);
            @(posedge clk_i); #1;
            auto_rsp   = 1'b0;
         end
      end
   end

   always @(negedge clk_i) begin
      if (ifu_req_valid_i && ifu_req_ready_o) grant_q.push_back(1'b0);
      if (lsu_req_valid_i && lsu_req_ready_o) grant_q.push_back(1'b1);
      if (ifu_rsp_valid_o) obs_q.push_back({1'b0, ifu_rdata_o});
      if (lsu_rsp_valid_o) obs_q.push_back({1'b1, lsu_rdata_o});
   end

   task automatic run_requests(input int n_ifu, input int n_lsu, input logic [31:0] ifu_base,
                               input logic [31:0] lsu_base, input int budget, output bit timed_out);
      int gi;
      int gl;
      bit fi;
      bit fl;
      gi = 0;
      gl = 0;
      timed_out = 1'b1;
      ifu_addr_i = ifu_base;
      ifu_req_valid_i = (n_ifu > 0);
      lsu_addr_i = lsu_base;
      lsu_wen_i = 1'b0;
      lsu_wdata_i = '0;
      lsu_wmask_i = '0;
      lsu_req_valid_i = (n_lsu > 0);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk_i);
         fi = ifu_req_valid_i && ifu_req_ready_o;
         fl = lsu_req_valid_i && lsu_req_ready_o;
         @(posedge clk_i); #1;
         if (fi) begin
            gi++;
            ifu_addr_i = ifu_base + 32'(4 * gi);
            if (gi >= n_ifu) ifu_req_valid_i = 1'b0;
         end
         if (fl) begin
            gl++;
            lsu_addr_i = lsu_base + 32'(4 * gl);
            if (gl >= n_lsu) lsu_req_valid_i = 1'b0;
         end
         if (gi == n_ifu && gl == n_lsu && obs_q.size() >= n_ifu + n_lsu && !busy_o) begin
            timed_out = 1'b0;
            break;
         end
      end
      ifu_req_valid_i = 1'b0;
      lsu_req_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0;
      ifu_req_valid_i = 1'b1;
      lsu_req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      checks++;
      if ({ifu_req_ready_o, lsu_req_ready_o, busy_o, mem_req_valid_o} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0000", {ifu_req_ready_o, lsu_req_ready_o, busy_o, mem_req_valid_o});
      end
      checks++;
      if ({mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o} !== 69'd0) begin
         failures++;
         $display("FAIL reset_mem_fields got=%h/%b/%h/%b exp=0", mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o);
      end
      rst_n_i = 1'b1;
      ifu_req_valid_i = 1'b0;
      lsu_req_valid_i = 1'b0;
      #1;
      checks++;
      if ({busy_o, ifu_rsp_valid_o, lsu_rsp_valid_o} !== 3'b000) begin
         failures++;
         $display("FAIL reset_idle got=%b exp=000", {busy_o, ifu_rsp_valid_o, lsu_rsp_valid_o});
      end
   endtask

   task automatic test_ifu_basic();
      rsp_t e;
      rsp_t o;
      @(posedge clk_i); #1;
      auto_mem = 1'b1;
      exp_q.delete(); obs_q.delete();
      ifu_req_valid_i = 1'b1;
      ifu_addr_i = 32'h8000_0000;
      exp_q.push_back({1'b0, 32'h0010_0073});
      #1;
      checks++;
      if ({ifu_req_ready_o, lsu_req_ready_o} !== 2'b10) begin
         failures++;
         $display("FAIL ifu_ready got=%b exp=10", {ifu_req_ready_o, lsu_req_ready_o});
      end
      @(posedge clk_i); #1;
      ifu_req_valid_i = 1'b0;
      #1;
      checks++;
      if ({mem_req_valid_o, mem_addr_o, mem_wen_o, busy_o} !== {1'b1, 32'h8000_0000, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL ifu_mem_req got=%b/%h/%b/%b exp=1/80000000/0/1", mem_req_valid_o, mem_addr_o, mem_wen_o, busy_o);
      end
      @(posedge clk_i); #2;
      checks++;
      if ({ifu_rsp_valid_o, lsu_rsp_valid_o, ifu_rdata_o} !== {2'b10, 32'h0010_0073}) begin
         failures++;
         $display("FAIL ifu_rsp got=%b%b/%h exp=10/00100073", ifu_rsp_valid_o, lsu_rsp_valid_o, ifu_rdata_o);
      end
      @(posedge clk_i); #2;
      checks++;
      if ({busy_o, ifu_rsp_valid_o} !== 2'b00) begin
         failures++;
         $display("FAIL ifu_back_idle got=%b exp=00", {busy_o, ifu_rsp_valid_o});
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL ifu_sb got=none exp=%h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL ifu_sb got=%h exp=%h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL ifu_sb_extra got=%0d exp=0", obs_q.size()); end
   endtask

   task automatic test_priority();
      rsp_t e;
      rsp_t o;
      bit   to;
      bit   g;
      bit   exp_g[2];
      @(posedge clk_i); #1;
      auto_mem = 1'b1;
      exp_q.delete(); obs_q.delete(); grant_q.delete();
      exp_g = '{1'b1, 1'b0};
      exp_q.push_back({1'b1, model_rdata(32'h8000_1000)});
      exp_q.push_back({1'b0, model_rdata(32'h8000_0040)});
      run_requests(1, 1, 32'h8000_0040, 32'h8000_1000, 60, to);
      checks++;
      if (to) begin failures++; $display("FAIL prio_timeout got=timeout exp=done"); end
      for (int i = 0; i < 2; i++) begin
         checks++;
         g = (grant_q.size() > 0) ? grant_q.pop_front() : !exp_g[i];
         if (g !== exp_g[i]) begin failures++; $display("FAIL prio_grant%0d got=%b exp=%b", i, g, exp_g[i]); end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL prio_sb got=none exp=%h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL prio_sb got=%h exp=%h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL prio_sb_extra got=%0d exp=0", obs_q.size()); end
   endtask

   task automatic test_starvation();
      rsp_t e;
      rsp_t o;
      bit   to;
      bit   g;
      bit   exp_g[8];
      int   li;
      int   ii;
      @(posedge clk_i); #1;
      auto_mem = 1'b1;
      exp_q.delete(); obs_q.delete(); grant_q.delete();
      // Four contested LSU grants, then the IFU is forced through, then the LSU resumes.
      exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      li = 0;
      ii = 0;
      for (int i = 0; i < 8; i++) begin
         if (exp_g[i]) begin
            exp_q.push_back({1'b1, model_rdata(32'h8000_2000 + 32'(4 * li))});
            li++;
         end else begin
            exp_q.push_back({1'b0, model_rdata(32'h8000_0800 + 32'(4 * ii))});
            ii++;
         end
      end
      run_requests(2, 6, 32'h8000_0800, 32'h8000_2000, 200, to);
      checks++;
      if (to) begin failures++; $display("FAIL starve_timeout got=timeout exp=done"); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         g = (grant_q.size() > 0) ? grant_q.pop_front() : !exp_g[i];
         if (g !== exp_g[i]) begin failures++; $display("FAIL starve_grant%0d got=%b exp=%b", i, g, exp_g[i]); end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL starve_sb got=none exp=%h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL starve_sb got=%h exp=%h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL starve_sb_extra got=%0d exp=0", obs_q.size()); end
   endtask

   task automatic test_write_backpressure();
      rsp_t e;
      rsp_t o;
      @(posedge clk_i); #1;
      auto_mem = 1'b0;
      man_ready = 1'b0;
      man_rsp = 1'b0;
      exp_q.delete(); obs_q.delete();
      lsu_req_valid_i = 1'b1;
      lsu_addr_i = 32'h8000_0010;
      lsu_wen_i = 1'b1;
      lsu_wdata_i = 32'hDEAD_BEEF;
      lsu_wmask_i = 4'b0011;
      exp_q.push_back({1'b1, 32'hCAFE_0001});
      #1;
      checks++;
      if ({lsu_req_ready_o, ifu_req_ready_o} !== 2'b10) begin
         failures++;
         $display("FAIL wr_ready got=%b exp=10", {lsu_req_ready_o, ifu_req_ready_o});
      end
      @(posedge clk_i); #1;
      lsu_req_valid_i = 1'b0;
      lsu_addr_i = '0;
      lsu_wen_i = 1'b0;
      lsu_wdata_i = '0;
      lsu_wmask_i = '0;
      for (int r = 0; r < 4; r++) begin
         man_ready = (r == 3);
         #1;
         checks++;
         if ({mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o}
             !== {1'b1, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011}) begin
            failures++;
            $display("FAIL wr_req_cycle%0d got=%b/%h/%b/%h/%b exp=1/80000010/1/deadbeef/0011",
                     r, mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o);
         end
         @(posedge clk_i); #1;
      end
      man_ready = 1'b0;
      #1;
      checks++;
      if ({mem_req_valid_o, busy_o, lsu_rsp_valid_o, mem_addr_o} !== {3'b010, 32'h8000_0010}) begin
         failures++;
         $display("FAIL wr_wait got=%b/%h exp=010/80000010", {mem_req_valid_o, busy_o, lsu_rsp_valid_o}, mem_addr_o);
      end
      @(posedge clk_i); #1;
      man_rsp = 1'b1;
      man_rdata = 32'hCAFE_0001;
      #1;
      checks++;
      if ({lsu_rsp_valid_o, ifu_rsp_valid_o} !== 2'b10) begin
         failures++;
         $display("FAIL wr_rsp got=%b exp=10", {lsu_rsp_valid_o, ifu_rsp_valid_o});
      end
      @(posedge clk_i); #1;
      man_rsp = 1'b0;
      #1;
      checks++;
      if ({busy_o, lsu_rsp_valid_o} !== 2'b00) begin
         failures++;
         $display("FAIL wr_done got=%b exp=00", {busy_o, lsu_rsp_valid_o});
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL wr_sb got=none exp=%h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL wr_sb got=%h exp=%h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL wr_sb_extra got=%0d exp=0", obs_q.size()); end
   endtask

   task automatic test_spurious_rsp();
      rsp_t e;
      rsp_t o;
      @(posedge clk_i); #1;
      auto_mem = 1'b0;
      exp_q.delete(); obs_q.delete();
      man_rsp = 1'b1;
      man_rdata = 32'h1111_1111;
      #1;
      checks++;
      if ({ifu_rsp_valid_o, lsu_rsp_valid_o, busy_o} !== 3'b000) begin
         failures++;
         $display("FAIL spur_idle got=%b exp=000", {ifu_rsp_valid_o, lsu_rsp_valid_o, busy_o});
      end
      @(posedge clk_i); #1;
      man_rsp = 1'b0;
      ifu_req_valid_i = 1'b1;
      ifu_addr_i = 32'h8000_0100;
      exp_q.push_back({1'b0, 32'h2222_2222});
      #1;
      checks++;
      if ({busy_o, mem_req_valid_o, ifu_req_ready_o} !== 3'b001) begin
         failures++;
         $display("FAIL spur_idle_kept got=%b exp=001", {busy_o, mem_req_valid_o, ifu_req_ready_o});
      end
      @(posedge clk_i); #1;
      ifu_req_valid_i = 1'b0;
      man_rsp = 1'b1;
      #1;
      checks++;
      if ({ifu_rsp_valid_o, lsu_rsp_valid_o, mem_req_valid_o} !== 3'b001) begin
         failures++;
         $display("FAIL spur_req got=%b exp=001", {ifu_rsp_valid_o, lsu_rsp_valid_o, mem_req_valid_o});
      end
      @(posedge clk_i); #1;
      man_rsp = 1'b0;
      #1;
      checks++;
      if (mem_req_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL spur_req_kept got=%b exp=1", mem_req_valid_o);
      end
      man_ready = 1'b1;
      @(posedge clk_i); #1;
      man_ready = 1'b0;
      man_rsp = 1'b1;
      man_rdata = 32'h2222_2222;
      @(posedge clk_i); #1;
      man_rsp = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL spur_sb got=none exp=%h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL spur_sb got=%h exp=%h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL spur_sb_extra got=%0d exp=0", obs_q.size()); end
   endtask

   task automatic test_reset_mid_wait();
      rsp_t e;
      rsp_t o;
      bit   to;
      @(posedge clk_i); #1;
      auto_mem = 1'b0;
      man_ready = 1'b0;
      man_rsp = 1'b0;
      ifu_req_valid_i = 1'b1;
      ifu_addr_i = 32'h8000_0200;
      @(posedge clk_i); #1;
      ifu_req_valid_i = 1'b0;
      man_ready = 1'b1;
      @(posedge clk_i); #1;
      man_ready = 1'b0;
      #1;
      checks++;
      if ({busy_o, mem_req_valid_o} !== 2'b10) begin
         failures++;
         $display("FAIL rst_pre_wait got=%b exp=10", {busy_o, mem_req_valid_o});
      end
      rst_n_i = 1'b0;
      ifu_req_valid_i = 1'b1;
      #1;
      checks++;
      if ({busy_o, ifu_req_ready_o, lsu_req_ready_o, ifu_rsp_valid_o, lsu_rsp_valid_o} !== 5'b00000) begin
         failures++;
         $display("FAIL rst_during got=%b exp=00000",
                  {busy_o, ifu_req_ready_o, lsu_req_ready_o, ifu_rsp_valid_o, lsu_rsp_valid_o});
      end
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      ifu_req_valid_i = 1'b0;
      exp_q.delete(); obs_q.delete();
      man_rsp = 1'b1;
      man_rdata = 32'h3333_3333;
      #1;
      checks++;
      if ({ifu_rsp_valid_o, lsu_rsp_valid_o, busy_o, mem_addr_o} !== {3'b000, 32'h0}) begin
         failures++;
         $display("FAIL rst_late_rsp got=%b/%h exp=000/00000000", {ifu_rsp_valid_o, lsu_rsp_valid_o, busy_o}, mem_addr_o);
      end
      @(posedge clk_i); #1;
      man_rsp = 1'b0;
      auto_mem = 1'b1;
      exp_q.push_back({1'b0, model_rdata(32'h8000_0300)});
      run_requests(1, 0, 32'h8000_0300, 32'h0, 40, to);
      checks++;
      if (to) begin failures++; $display("FAIL rst_after_timeout got=timeout exp=done"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL rst_after_sb got=none exp=%h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL rst_after_sb got=%h exp=%h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL rst_after_sb_extra got=%0d exp=0", obs_q.size()); end
   endtask

   initial begin
      rst_n_i = 1'b0;
      ifu_req_valid_i = 1'b0;
      ifu_addr_i = '0;
      lsu_req_valid_i = 1'b0;
      lsu_addr_i = '0;
      lsu_wen_i = 1'b0;
      lsu_wdata_i = '0;
      lsu_wmask_i = '0;
      auto_mem = 1'b0;
      man_ready = 1'b0;
      man_rsp = 1'b0;
      man_rdata = '0;
      test_reset();
      test_ifu_basic();
      test_priority();
      test_starvation();
      test_write_backpressure();
      test_spurious_rsp();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle NPC core. Each request is accepted over a valid/ready handshake and issued to memory. The block waits for the memory response and routes it back to the requester that owns the transaction. The LSU has fixed priority, with a bounded-starvation override for the IFU. At most one transaction is outstanding.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; must be a multiple of 8
- MAX_LSU_BURST, 4, consecutive contested LSU grants allowed before the IFU is forced through; must be ≥1
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset; synchronous, active-low; one clock
- ifu_req_valid_i / ifu_req_ready_o  in/out  1  IFU read request handshake
- ifu_addr_i  in  ADDR_WIDTH  IFU fetch address
- ifu_rsp_valid_o  out  1  one-cycle IFU response strobe
- ifu_rdata_o  out  DATA_WIDTH  IFU read data
- lsu_req_valid_i / lsu_req_ready_o  in/out  1  LSU request handshake
- lsu_addr_i  in  ADDR_WIDTH  LSU address
- lsu_wen_i  in  1  1 = write, 0 = read
- lsu_wdata_i  in  DATA_WIDTH  write data
- lsu_wmask_i  in  DATA_WIDTH/8  byte write enables
- lsu_rsp_valid_o  out  1  one-cycle LSU response strobe; also pulses for writes
- lsu_rdata_o  out  DATA_WIDTH  LSU read data; don't-care for writes
- mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake
- mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o  out  as LSU  registered request fields
- mem_rsp_valid_i  in  1  memory response strobe
- mem_rdata_i  in  DATA_WIDTH  memory read data
- busy_o  out  1  high whenever state ≠ IDLE

## Operation
- FSM states and transitions:
  - IDLE → REQ on a handshake fire.
  - REQ → WAIT when mem_req_ready_i=1.
  - WAIT → IDLE when mem_rsp_valid_i=1.
- Owner register: 0 = IFU, 1 = LSU. It is written at grant.
- Grant, computed only in IDLE:
  - Only one requester valid: that requester wins.
  - Both valid: LSU wins, unless lsu_streak == MAX_LSU_BURST, in which case IFU wins.
- Ready signals:
  - ifu_req_ready_o = IDLE & grant_ifu.
  - lsu_req_ready_o = IDLE & grant_lsu.
  - At most one ready is high per cycle, and ready never asserts outside IDLE.
- On fire:
  - Latch address, wen, wdata and wmask into the mem_* registers.
  - An IFU fire latches wen=0, wmask=0 and wdata=0.
- lsu_streak counter, width clog2(MAX_LSU_BURST+1):
  - LSU grant with ifu_req_valid_i=1: increment, saturating at MAX_LSU_BURST.
  - LSU grant with ifu_req_valid_i=0: clear.
  - IFU grant: clear.
- mem_req_valid_o = (state == REQ).
- mem_* fields stay stable from REQ entry until the transaction returns to IDLE.
- Response routing:
  - ifu_rsp_valid_o = WAIT & mem_rsp_valid_i & owner==IFU.
  - lsu_rsp_valid_o = WAIT & mem_rsp_valid_i & owner==LSU.
  - Both rdata outputs pass mem_rdata_i through combinationally.
- mem_rsp_valid_i in IDLE or REQ is ignored: no strobe, no state change.
- Requesters must hold valid and fields stable until ready. The arbiter does not check this.

## Timing
- Reset, while rst_n_i=0 at a rising edge:
  - state=IDLE, owner=IFU, lsu_streak=0, mem_* registers=0.
  - All *_valid_o, *_ready_o and busy_o are forced to 0 during the reset cycle.
- Reset mid-transaction abandons the transaction. A late mem_rsp_valid_i after reset is ignored.
- Best case for fire at cycle N:
  - mem_req_valid_o=1 at N+1; with mem_req_ready_i=1, WAIT at N+2.
  - With mem_rsp_valid_i=1 at N+2, the rsp strobe is at N+2 and state is IDLE at N+3.
  - Next fire at N+3, giving a minimum of 3 cycles per transaction.
- Backpressure: each cycle with mem_req_ready_i=0 in REQ adds one cycle, fields held.
- Each cycle without mem_rsp_valid_i in WAIT adds one cycle.
- No combinational path from any *_req_valid_i to mem_*. Combinational paths exist req_valid → req_ready and mem_rsp → rsp_*.

## Test plan
- IFU only, addr 0x8000_0000, memory ready immediately, rdata 0x0010_0073 one cycle later → ifu_req_ready_o=1 at fire cycle N; mem_addr_o=0x8000_0000, mem_wen_o=0 at N+1; ifu_rsp_valid_o=1 with 0x0010_0073 at N+2; lsu_rsp_valid_o stays 0.
- IFU and LSU valid together, lsu_streak=0 → LSU granted; IFU granted next IDLE after the LSU response.
- IFU held valid, LSU re-requesting every IDLE, MAX_LSU_BURST=4 → grant order LSU, LSU, LSU, LSU, IFU, LSU…
- LSU write addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask 4'b0011, mem_req_ready_i low for 3 cycles → mem_* fields stable for 4 REQ cycles; lsu_rsp_valid_o pulses once on response.
- Spurious mem_rsp_valid_i in IDLE and in REQ → no rsp strobe, state unchanged.
- rst_n_i low for one cycle while in WAIT, then mem_rsp_valid_i=1 → state IDLE, busy_o=0, no rsp strobe; next IFU request served normally.
